// File: rtl/fifo_byte_drain.sv
// -----------------------------------------------------------------------------
// fifo_byte_drain
//
// Read-side consumer for the shift-register FIFO. When the FIFO reports a
// pending word, it captures the oldest word from the FIFO mux output and
// issues a one-cycle pop strobe. If the upstream pushes in that cycle, the
// FIFO ignores both operations, so the strobe is repeated. The word is then
// serialised as WIDTH/8 bytes on an 8-bit valid/ready stream. The block also
// records upstream overflow attempts and counts fully transmitted words.
//
// Stream handshake: a byte transfers on a rising clock edge where m_valid_o
// and m_ready_i are both high. Once m_valid_o is raised, it and m_data_o and
// m_last_o are held until that transfer. m_valid_o never depends on
// m_ready_i.
//
// Ports
//   clk_i          clock
//   rst_i          asynchronous active-low reset
//   en_i           drain enable; gates only the start of a new word
//   fifo_pnding_i  FIFO non-empty flag (registered, lags count by a cycle)
//   fifo_full_i    FIFO full flag
//   fifo_push_i    copy of the FIFO push strobe (monitor only)
//   fifo_data_i    FIFO mux output (oldest word)
//   fifo_pop_o     pop strobe to the FIFO
//   m_data_o       byte out
//   m_valid_o      byte valid
//   m_ready_i      sink ready
//   m_last_o       high with the final byte of a word
//   busy_o         FSM not in IDLE (state visibility)
//   word_cnt_o     words fully transmitted, wraps modulo 2^16
//   ovf_o          sticky: push attempted while full
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module fifo_byte_drain #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             fifo_pnding_i,
  input  logic             fifo_full_i,
  input  logic             fifo_push_i,
  input  logic [WIDTH-1:0] fifo_data_i,
  output logic             fifo_pop_o,
  output logic [7:0]       m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic             m_last_o,
  output logic             busy_o,
  output logic [15:0]      word_cnt_o,
  output logic             ovf_o
);

  if (((WIDTH % 8) != 0) || (WIDTH < 8) || (DEPTH < 1)) begin : g_bad_params
    $error("fifo_byte_drain: WIDTH must be a positive multiple of 8 and DEPTH >= 1");
  end

  localparam int NB   = WIDTH / 8;
  localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NB - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_POP  = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             pop_q, pop_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [7:0]       data_q, data_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             busy_q;
  logic             ovf_q, ovf_d;

  // The byte to present next always sits at the head end of the shift
  // register; after taking it the register moves by one byte toward that end.
  logic [7:0]       head_byte;
  logic [WIDTH-1:0] shift_next;

  always_comb begin
    if (MSB_FIRST) begin
      head_byte  = shift_q[WIDTH-1 -: 8];
      shift_next = shift_q << 8;
    end else begin
      head_byte  = shift_q[7:0];
      shift_next = shift_q >> 8;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    pop_d   = pop_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (en_i && fifo_pnding_i) begin
          shift_d = fifo_data_i;
          idx_d   = '0;
          pop_d   = 1'b1;
          state_d = ST_POP;
        end
      end

      ST_POP: begin
        // A push in the same cycle makes the FIFO drop the pop; hold the
        // strobe for another cycle. The captured word is still the oldest.
        if (!fifo_push_i) begin
          pop_d   = 1'b0;
          valid_d = 1'b1;
          data_d  = head_byte;
          last_d  = (idx_q == LAST_IDX);
          shift_d = shift_next;
          state_d = ST_SEND;
        end
      end

      ST_SEND: begin
        if (valid_q && m_ready_i) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            cnt_d   = cnt_q + 16'd1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + IDXW'(1);
            data_d  = head_byte;
            last_d  = ((idx_q + IDXW'(1)) == LAST_IDX);
            shift_d = shift_next;
          end
        end
      end

      default: begin
        pop_d   = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Overflow compares against the registered pop: a push that coincides with
  // our pop strobe is dropped by the FIFO, not lost to a full condition.
  assign ovf_d = ovf_q | (fifo_full_i & fifo_push_i & ~pop_q);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      pop_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= 8'd0;
      cnt_q   <= 16'd0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      pop_q   <= pop_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != ST_IDLE);
      ovf_q   <= ovf_d;
    end
  end

  assign fifo_pop_o = pop_q;
  assign m_data_o   = data_q;
  assign m_valid_o  = valid_q;
  assign m_last_o   = last_q;
  assign busy_o     = busy_q;
  assign word_cnt_o = cnt_q;
  assign ovf_o      = ovf_q;

endmodule
